// File: rtl/fifo_stream_pkg.sv
// Shared types for the async-FIFO read-side stream stage.
// Pure typedefs and constants; no latency, no flow control.
package fifo_stream_pkg;
  localparam int DEF_DW = 32;

  typedef struct packed {
    logic [DEF_DW-1:0] data;
    logic              last;
  } stream_beat_t;

  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// 2-entry in-order shift buffer; a push lands in the first free slot, a pop shifts entry 1 to the head.
// Latency: a push into an empty buffer is on head one edge later; push is refused upstream at occ=2.
module fifo_rd_skid #(
  parameter int W = fifo_stream_pkg::DEF_DW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);
  import fifo_stream_pkg::*;

  occ_t         occ_q;
  logic [W-1:0] ent0;
  logic [W-1:0] ent1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) ent0 <= din;
          else               ent1 <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          occ_q <= occ_q - 2'd1;
        end
        // Occupancy is unchanged; with one entry the new word replaces the leaving head.
        2'b11: begin
          if (occ_q == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ  = occ_q;
  assign head = ent0;

  assert property (@(posedge clk) disable iff (!rst_n) !(push && occ_q == 2'd2));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && occ_q == 2'd0));
  assert property (@(posedge clk) disable iff (!rst_n) occ_q <= 2'd2);
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a show-ahead FIFO into a valid/ready stream, tagging the last word of each fixed-length frame.
// Latency: pop at edge N is on m_data at edge N+1; m_ready low holds outputs and stops pops at 2 buffered.
module fifo_rd_stream #(
  parameter int DW        = fifo_stream_pkg::DEF_DW,
  parameter int FRAME_LEN = 16,
  parameter int FCW       = 16
) (
  input  logic           rclk,
  input  logic           rrst_n,
  input  logic           en,
  input  logic [DW-1:0]  rdata,
  input  logic           rempty,
  output logic           rinc,
  output logic [DW-1:0]  m_data,
  output logic           m_valid,
  output logic           m_last,
  input  logic           m_ready,
  output logic [FCW-1:0] frame_cnt,
  output logic           busy
);
  import fifo_stream_pkg::*;

  localparam int             BCW       = 16;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(FRAME_LEN - 1);

  occ_t           occ;
  logic [DW:0]    head;
  logic [BCW-1:0] beat_cnt;
  logic [FCW-1:0] frame_q;
  logic           accept;
  logic           tag_last;

  // Registered occupancy only: an output pop in the same cycle does not free a slot early.
  assign rinc     = rrst_n & en & ~rempty & (occ < 2'd2);
  assign accept   = m_valid & m_ready;
  assign tag_last = (beat_cnt == LAST_BEAT);

  fifo_rd_skid #(.W(DW + 1)) u_skid (
    .clk   (rclk),
    .rst_n (rrst_n),
    .push  (rinc),
    .din   ({rdata, tag_last}),
    .pop   (accept),
    .occ   (occ),
    .head  (head)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head[DW:1];
  assign m_last  = head[0];

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      beat_cnt <= '0;
      frame_q  <= '0;
    end else begin
      if (rinc) beat_cnt <= tag_last ? '0 : beat_cnt + 1'b1;
      if (accept && m_last) frame_q <= frame_q + 1'b1;
    end
  end

  assign frame_cnt = frame_q;
  assign busy      = (occ != 2'd0) || (beat_cnt != '0);
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with FRAME_LEN=4 and a queue-based show-ahead FIFO model.
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_fifo_rd_stream;
  import fifo_stream_pkg::*;

  localparam int DW  = 32;
  localparam int FL  = 4;
  localparam int FCW = 16;

  logic           rclk = 1'b0;
  logic           rrst_n, en, rempty, rinc, m_valid, m_last, m_ready, busy;
  logic [DW-1:0]  rdata, m_data;
  logic [FCW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  src_q[$];
  stream_beat_t   sb[$];
  stream_beat_t   acc_log[$];
  int             exp_occ, exp_beat, pop_cnt, cyc;
  int             first_pop_cyc, first_acc_cyc, last_acc_cyc;
  logic [FCW-1:0] exp_frames;
  bit             gap_en, gap_phase, pend_pop;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DW(DW), .FRAME_LEN(FL), .FCW(FCW)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .en        (en),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic refresh();
    rempty = (src_q.size() == 0) || (gap_en && gap_phase);
    rdata  = (src_q.size() != 0) ? src_q[0] : 32'hDEAD_BEEF;
  endtask

  // Compares this cycle's outputs against the model, then advances the model across the coming edge.
  task automatic score();
    logic         exp_rinc;
    stream_beat_t b;
    exp_rinc = rrst_n && en && !rempty && (exp_occ < 2);
    checks++;
    if (rinc !== exp_rinc) begin
      errors++;
      $display("FAIL rinc cyc=%0d got %b exp %b (rempty=%b)", cyc, rinc, exp_rinc, rempty);
    end
    checks++;
    if (m_valid !== (exp_occ != 0)) begin
      errors++;
      $display("FAIL m_valid cyc=%0d got %b exp %b", cyc, m_valid, exp_occ != 0);
    end
    checks++;
    if (busy !== (exp_occ != 0 || exp_beat != 0)) begin
      errors++;
      $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, exp_occ != 0 || exp_beat != 0);
    end
    checks++;
    if (frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL frame_cnt cyc=%0d got %0d exp %0d", cyc, frame_cnt, exp_frames);
    end
    if (exp_occ != 0 && sb.size() != 0) begin
      checks++;
      if (m_data !== sb[0].data || m_last !== sb[0].last) begin
        errors++;
        $display("FAIL head cyc=%0d got %h/%b exp %h/%b", cyc, m_data, m_last, sb[0].data, sb[0].last);
      end
    end
    if (!rrst_n) begin
      sb.delete();
      exp_occ    = 0;
      exp_beat   = 0;
      exp_frames = '0;
      pend_pop   = 1'b0;
    end else begin
      if (exp_occ != 0 && m_ready && sb.size() != 0) begin
        acc_log.push_back(sb[0]);
        if (sb[0].last) exp_frames++;
        void'(sb.pop_front());
        exp_occ--;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
      end
      pend_pop = (rinc === 1'b1) && !rempty;
      if (pend_pop) begin
        b.data = rdata;
        b.last = (exp_beat == FL - 1);
        sb.push_back(b);
        exp_beat = (exp_beat == FL - 1) ? 0 : exp_beat + 1;
        exp_occ++;
        pop_cnt++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
  endtask

  task automatic step();
    refresh();
    @(negedge rclk);
    score();
    @(posedge rclk);
    #1;
    if (pend_pop) void'(src_q.pop_front());
    pend_pop  = 1'b0;
    gap_phase = ~gap_phase;
    cyc++;
  endtask

  task automatic apply_reset();
    rrst_n = 1'b0;
    step();
    rrst_n        = 1'b1;
    acc_log.delete();
    pop_cnt       = 0;
    first_pop_cyc = -1;
    first_acc_cyc = -1;
    last_acc_cyc  = -1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (src_q.size() == 0 && exp_occ == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; en = 1'b1; m_ready = 1'b1; gap_en = 1'b0;
    rempty = 1'b1; rdata = '0;
    @(posedge rclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rinc !== 1'b0 || m_valid !== 1'b0 || frame_cnt !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state i=%0d got rinc=%b vld=%b fc=%0d busy=%b exp 0/0/0/0",
                 i, rinc, m_valid, frame_cnt, busy);
      end
    end
    rrst_n = 1'b1;
    step();
    step();
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin
      errors++;
      $display("FAIL idle got vld=%b busy=%b data=%h exp 0/0/0", m_valid, busy, m_data);
    end
  endtask

  task automatic test_streaming();
    bit ok;
    apply_reset();
    m_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back(32'(i));
    wait_idle(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stream_drain got not idle exp idle within 60 cycles"); end
    checks++;
    if (first_acc_cyc != first_pop_cyc + 1) begin
      errors++;
      $display("FAIL stream_latency got first accept %0d exp %0d", first_acc_cyc, first_pop_cyc + 1);
    end
    checks++;
    if (last_acc_cyc - first_acc_cyc != 7) begin
      errors++;
      $display("FAIL stream_rate got span %0d exp 7", last_acc_cyc - first_acc_cyc);
    end
    checks++;
    if (acc_log.size() != 8) begin
      errors++;
      $display("FAIL stream_count got %0d exp 8", acc_log.size());
    end
    for (int i = 0; i < acc_log.size(); i++) begin
      checks++;
      if (acc_log[i].data !== 32'(i) || acc_log[i].last !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL stream_beat%0d got %h/%b exp %h/%b", i, acc_log[i].data, acc_log[i].last, i, i % 4 == 3);
      end
    end
    checks++;
    if (frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stream_frames got %0d exp 2", frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    m_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) src_q.push_back(32'(i));
    for (int i = 0; i < 6; i++) step();
    refresh();
    #1;
    checks++;
    if (pop_cnt != 2) begin errors++; $display("FAIL bp_pops got %0d exp 2", pop_cnt); end
    checks++;
    if (rinc !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got rinc=%b vld=%b data=%h last=%b exp 0/1/0/0", rinc, m_valid, m_data, m_last);
    end
    m_ready = 1'b1;
    wait_idle(40, ok);
    checks++;
    if (!ok || acc_log.size() != 3) begin
      errors++;
      $display("FAIL bp_drain got %0d words exp 3", acc_log.size());
    end
    for (int i = 0; i < acc_log.size(); i++) begin
      checks++;
      if (acc_log[i].data !== 32'(i)) begin
        errors++;
        $display("FAIL bp_order%0d got %h exp %h", i, acc_log[i].data, i);
      end
    end
    checks++;
    if (frame_cnt !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_state got fc=%0d busy=%b exp 0/1", frame_cnt, busy);
    end
  endtask

  task automatic test_empty_gaps();
    bit ok;
    apply_reset();
    m_ready = 1'b1; en = 1'b1; gap_en = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back(32'h40 + 32'(i));
    wait_idle(100, ok);
    gap_en = 1'b0;
    checks++;
    if (!ok || acc_log.size() != 8) begin
      errors++;
      $display("FAIL gap_drain got %0d words exp 8", acc_log.size());
    end
    for (int i = 0; i < acc_log.size(); i++) begin
      checks++;
      if (acc_log[i].data !== 32'h40 + 32'(i) || acc_log[i].last !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL gap_beat%0d got %h/%b exp %h/%b", i, acc_log[i].data, acc_log[i].last, 32'h40 + i, i % 4 == 3);
      end
    end
    checks++;
    if (frame_cnt !== 16'd2) begin errors++; $display("FAIL gap_frames got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_en_low();
    bit ok;
    apply_reset();
    m_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(32'h20 + 32'(i));
    for (int i = 0; i < 20 && pop_cnt < 3; i++) step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (pop_cnt != 3 || m_valid !== 1'b0 || busy !== 1'b1 || frame_cnt !== '0) begin
      errors++;
      $display("FAIL en_hold got pops=%0d vld=%b busy=%b fc=%0d exp 3/0/1/0", pop_cnt, m_valid, busy, frame_cnt);
    end
    en = 1'b1;
    wait_idle(30, ok);
    checks++;
    if (!ok || acc_log.size() != 4) begin
      errors++;
      $display("FAIL en_drain got %0d words exp 4", acc_log.size());
    end else begin
      checks++;
      if (acc_log[3].data !== 32'h23 || acc_log[3].last !== 1'b1 || acc_log[2].last !== 1'b0) begin
        errors++;
        $display("FAIL en_last got %h/%b prev last %b exp 23/1 prev 0", acc_log[3].data, acc_log[3].last, acc_log[2].last);
      end
    end
    checks++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_frames got fc=%0d busy=%b exp 1/0", frame_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    apply_reset();
    m_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) src_q.push_back(32'h30 + 32'(i));
    for (int i = 0; i < 20 && exp_occ < 2; i++) step();
    checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1 || pop_cnt != 2) begin
      errors++;
      $display("FAIL rmf_setup got vld=%b busy=%b pops=%0d exp 1/1/2", m_valid, busy, pop_cnt);
    end
    rrst_n = 1'b0;
    step();
    rrst_n = 1'b1;
    checks++;
    if (m_valid !== 1'b0 || frame_cnt !== '0 || busy !== 1'b0 || m_data !== '0) begin
      errors++;
      $display("FAIL rmf_cleared got vld=%b fc=%0d busy=%b data=%h exp 0/0/0/0", m_valid, frame_cnt, busy, m_data);
    end
    m_ready = 1'b1;
    acc_log.delete();
    wait_idle(40, ok);
    checks++;
    if (!ok || acc_log.size() != 4) begin
      errors++;
      $display("FAIL rmf_drain got %0d words exp 4", acc_log.size());
    end
    for (int i = 0; i < acc_log.size(); i++) begin
      checks++;
      if (acc_log[i].data !== 32'h32 + 32'(i) || acc_log[i].last !== (i == 3)) begin
        errors++;
        $display("FAIL rmf_beat%0d got %h/%b exp %h/%b", i, acc_log[i].data, acc_log[i].last, 32'h32 + i, i == 3);
      end
    end
    checks++;
    if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rmf_frames got %0d exp 1", frame_cnt); end
  endtask

  initial begin
    exp_occ = 0; exp_beat = 0; exp_frames = '0; pop_cnt = 0; cyc = 0;
    first_pop_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    gap_phase = 1'b0; pend_pop = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_gaps();
    test_en_low();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of the async FIFO and runs in the rclk domain.
- Pops words through the FIFO's show-ahead read port (rdata, rinc, rempty) and presents them as a valid/ready stream.
- Tags the last word of every fixed-length frame.
- A 2-entry registered buffer decouples FIFO pops from downstream backpressure and sustains one word per cycle.

Parameters:
- DW, 32, data width; matches the FIFO rdata width.
- FRAME_LEN, 16, words per frame; legal range 1..65535.
- FCW, 16, width of the frame counter output.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  synchronous active-low reset, sampled on the rising edge of rclk.
- en  in  1  fetch enable; when low, no new FIFO pops; buffered words still drain.
- rdata  in  DW  FIFO head word; valid whenever rempty=0.
- rempty  in  1  FIFO empty flag.
- rinc  out  1  FIFO pop strobe.
- m_data  out  DW  stream data.
- m_valid  out  1  stream valid.
- m_last  out  1  final word of a frame.
- m_ready  in  1  downstream accept.
- frame_cnt  out  FCW  completed frames delivered; wraps modulo 2^FCW.
- busy  out  1  occ!=0 or beat_cnt!=0, i.e. a frame is in progress.

Behaviour:
- Reset (rrst_n=0 at an rclk edge):
  - occ=0, beat_cnt=0, frame_cnt=0.
  - m_valid=0, m_last=0, m_data=0, busy=0.
  - rinc is forced to 0 while rrst_n=0.
- Mid-operation reset: buffered words are discarded. The next frame starts at beat 0.
- FIFO semantics: show-ahead. rinc=1 with rempty=0 at an edge consumes rdata at that edge.
- Pop rule, combinational: rinc = rrst_n & en & ~rempty & (occ<2).
  - occ is the registered value only; there is no same-cycle credit from an output pop.
  - rinc never asserts while rempty=1.
- Fetch: on an edge with rinc=1, {rdata, beat_cnt==FRAME_LEN-1} is written to the buffer tail.
  - beat_cnt increments, wrapping FRAME_LEN-1 -> 0.
- Output:
  - m_valid = (occ!=0), from flops.
  - m_data and m_last come from the head entry, also registered.
  - No combinational path from m_ready or rempty to m_data, m_valid or m_last.
- Accept: an edge with m_valid & m_ready removes the head entry; entry 1 shifts to the head.
- Simultaneous fetch and accept: occ is unchanged and ordering is preserved. With occ=1 this gives 1 word/cycle steady-state throughput.
- Latency: a word popped at edge N is on m_data at edge N+1 when occ was 0 at edge N.
- Backpressure: m_ready=0 holds m_data, m_valid and m_last stable until accepted. Fetching stops at occ=2.
- Frame counting: frame_cnt increments on an edge with m_valid & m_ready & m_last. It wraps 2^FCW-1 -> 0.
- FRAME_LEN=1: every word has m_last=1.
- en low mid-frame: beat_cnt is held and the frame resumes when en returns high. A frame is never force-terminated.
- occ never exceeds 2. Buffer underflow or overflow is impossible by construction; verify this with assertions.

Decomposition:
- Package fifo_stream_pkg holds:
  - the DW default;
  - typedef stream_beat_t, a struct {logic [DW-1:0] data; logic last;};
  - typedef occ_t, logic [1:0].
- One sub-module, fifo_rd_skid: a 2-entry shift buffer with push/pop/occ and head outputs. The top level holds only the pop rule, beat_cnt and frame_cnt.

Test Plan:
- Reset then idle: rrst_n=0 for 3 cycles, rempty=1 -> rinc=0, m_valid=0, frame_cnt=0, busy=0 throughout.
- Streaming, FRAME_LEN=4: FIFO holds 0x00..0x07 and m_ready=1 -> first m_valid one cycle after the first rinc. Then 8 consecutive beats 0x00..0x07, m_last on 0x03 and 0x07, frame_cnt=2.
- Backpressure: m_ready=0 with FIFO non-empty -> exactly 2 pops. rinc then stays 0, m_data=0x00 holds. On m_ready=1, the order 0x00, 0x01, 0x02 is preserved with no loss.
- Empty gaps: rempty toggles every other cycle -> rinc never asserts with rempty=1. Output order intact, beat_cnt counted across gaps.
- en low mid-frame: en=0 after beat 2 of 4 -> buffered words drain, no pops. After en=1, beat 3 carries m_last, frame_cnt=1.
- Reset mid-frame: rrst_n=0 while occ=2 and beat_cnt=2 -> m_valid=0 next cycle, frame_cnt=0. The next popped word starts a fresh frame with m_last on its 4th beat.
